// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: ALU control decode, ID/EX pipeline register, operand forwarding and load-use
// detection. Define ALU_FWD_EN to enable EX/MEM and MEM/WB forwarding into the ALU operands.
module id_ex_alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [2:0]  ex_alu_control,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wreg,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_illegal,
    output logic        load_use_stall
);

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_control;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        alu_src;
        logic [4:0]  wreg;
        logic        reg_write;
        logic        mem_read;
        logic        illegal;
    } idex_t;

    idex_t      idex_q, idex_d, id_fields;
    logic [2:0] dec_ctrl;
    logic       dec_illegal;

    always_comb begin
        dec_ctrl    = 3'b010;
        dec_illegal = 1'b0;
        case (id_alu_op)
            2'b00: dec_ctrl = 3'b010;
            2'b01: dec_ctrl = 3'b110;
            2'b11: dec_ctrl = 3'b001;
            default: begin
                case (id_funct)
                    6'b100000: dec_ctrl = 3'b010;
                    6'b100010: dec_ctrl = 3'b110;
                    6'b100100: dec_ctrl = 3'b000;
                    6'b100101: dec_ctrl = 3'b001;
                    6'b101010: dec_ctrl = 3'b111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        id_fields             = '0;
        id_fields.valid       = id_valid;
        id_fields.alu_control = dec_ctrl;
        id_fields.rs          = id_rs;
        id_fields.rt          = id_rt;
        id_fields.rs_data     = id_rs_data;
        id_fields.rt_data     = id_rt_data;
        id_fields.imm         = id_imm;
        id_fields.alu_src     = id_alu_src;
        id_fields.wreg        = id_reg_dst ? id_rd : id_rt;
        id_fields.reg_write   = id_reg_write & id_valid;
        id_fields.mem_read    = id_mem_read;
        id_fields.illegal     = dec_illegal;
    end

    // Flush beats stall; a bubble is simply the all-zero record.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (stall) begin
            idex_d = idex_q;
        end else if (load_use_stall) begin
            idex_d = '0;
        end else begin
            idex_d = id_fields;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    logic [31:0] fwd_rs, fwd_rt;
    logic        ld_hazard, wr_hazard;

    assign ld_hazard = idex_q.valid & idex_q.mem_read & (idex_q.wreg != 5'd0) & id_valid &
                       ((idex_q.wreg == id_rs) | (idex_q.wreg == id_rt));

`ifdef ALU_FWD_EN
    always_comb begin
        fwd_rs = idex_q.rs_data;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_q.rs) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_q.rs) begin
            fwd_rs = memwb_result;
        end
    end

    always_comb begin
        fwd_rt = idex_q.rt_data;
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_q.rt) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_q.rt) begin
            fwd_rt = memwb_result;
        end
    end

    assign wr_hazard = 1'b0;
`else
    function automatic logic src_hit(input logic we, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
        return we & (rd != 5'd0) & ((rd == rs) | (rd == rt));
    endfunction

    // Without forwarding, any in-flight writer of an ID source must drain first.
    assign wr_hazard = id_valid & (src_hit(idex_q.reg_write, idex_q.wreg, id_rs, id_rt) |
                                   src_hit(exmem_reg_write, exmem_rd, id_rs, id_rt) |
                                   src_hit(memwb_reg_write, memwb_rd, id_rs, id_rt));

    assign fwd_rs = idex_q.rs_data;
    assign fwd_rt = idex_q.rt_data;

    logic unused_results;
    assign unused_results = ^{exmem_result, memwb_result};
`endif

    assign load_use_stall = ~stall & (ld_hazard | wr_hazard);

    assign ex_valid       = idex_q.valid;
    assign ex_alu_control = idex_q.alu_control;
    assign ex_a           = fwd_rs;
    assign ex_b           = idex_q.alu_src ? idex_q.imm : fwd_rt;
    assign ex_store_data  = fwd_rt;
    assign ex_wreg        = idex_q.wreg;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_illegal     = idex_q.illegal;

endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

ID/EX issue stage that drives the Execute-stage ALU. It decodes ALUOp/funct into the ALU's 3-bit control code and registers operands and control on the ID/EX boundary, with stall, flush and bubble handling. It also forwards EX/MEM and MEM/WB results into the ALU operands and detects load-use hazards. It sits between the decode stage and the ALU.

## Interface
- No parameters; datapath fixed at 32 bits, register specifiers at 5 bits.
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode stage holds a real instruction
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- id_funct  in  6  R-type funct field
- id_rs, id_rt, id_rd  in  5 each  source and destination specifiers
- id_rs_data, id_rt_data, id_imm  in  32 each  register-file reads; sign/zero-extended immediate
- id_alu_src  in  1  1 selects imm as ALU operand B
- id_reg_dst  in  1  1 selects rd as write register, 0 selects rt
- id_reg_write, id_mem_read  in  1 each  decode-stage control
- stall  in  1  downstream stall; hold the ID/EX register
- flush  in  1  kill the instruction entering EX
- exmem_reg_write, exmem_rd, exmem_result  in  1/5/32  EX/MEM writer
- memwb_reg_write, memwb_rd, memwb_result  in  1/5/32  MEM/WB writer
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- ex_a, ex_b  out  32 each  ALU operands, after forwarding and the alu_src mux
- ex_store_data  out  32  forwarded rt value for stores
- ex_wreg  out  5  destination register
- ex_reg_write, ex_mem_read, ex_illegal  out  1 each  registered control signals
- load_use_stall  out  1  request to hold IF/ID; this block inserts the bubble itself

## Operation
- Decode:
  - alu_op 00 decodes to 010; 01 to 110; 11 to 001.
  - alu_op 10 decodes by funct: 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111.
  - An unknown funct decodes to 010 with ex_illegal=1.
- Registered fields: valid, alu_control, rs, rt, rs_data, rt_data, imm, alu_src, wreg (rd if reg_dst else rt), reg_write (gated by id_valid), mem_read, illegal.
- Next-state priority per edge:
  - reset: clear all registers.
  - else flush: bubble.
  - else stall: hold all registers.
  - else load_use_stall: bubble.
  - else load the decode-stage values.
- Bubble: valid=0, alu_control=000, reg_write=0, mem_read=0, illegal=0, wreg=0, data fields=0.
- Forwarding (combinational on the registered rs/rt):
  - The EX/MEM writer matches when exmem_reg_write=1, exmem_rd!=0 and exmem_rd equals the source specifier; it then supplies the value.
  - Otherwise the MEM/WB writer supplies the value under the same conditions.
  - Otherwise the registered register-file data is used.
  - EX/MEM wins when both writers match.
- ex_b = alu_src ? imm : forwarded rt. ex_store_data is always the forwarded rt.
- load_use_stall = ex_valid & ex_mem_read & ex_wreg!=0 & id_valid & (ex_wreg==id_rs | ex_wreg==id_rt). The signal is combinational and is suppressed while stall=1.

## Timing
- Latency is one cycle from the decode-stage inputs to the registered EX outputs. ex_a, ex_b and ex_store_data also follow exmem_*/memwb_* within the same cycle.
- Reset value of every registered output is 0. After reset, ex_a, ex_b, ex_store_data and load_use_stall evaluate to 0.
- A load-use hazard produces exactly one bubble. On the next cycle ex_mem_read=0, so load_use_stall deasserts and the held instruction loads.
- flush together with stall: flush wins. flush together with load_use_stall: flush wins, and the external hazard logic still holds IF/ID.
- During stall, registers hold but forwarded operands track the writer ports live.
- A register-0 destination is never forwarded and never triggers a hazard.

## Configuration
- ALU_FWD_EN defined: forwarding behaves as described above.
- ALU_FWD_EN undefined:
  - The exmem_*/memwb_* ports still exist, but only for hazard detection.
  - Operands come from registered data only.
  - load_use_stall additionally asserts on any id_rs/id_rt match (nonzero) against an active ex_wreg, exmem_rd or memwb_rd writer whose reg_write=1.

## Test plan
- R-type decode: alu_op=10 with funct 100000/100010/100100/100101/101010/111111 -> ex_alu_control 010/110/000/001/111/010 one cycle later; ex_illegal=1 only for 111111.
- Forwarding: exmem and memwb both write r5 (0x11, 0x22), EX instruction reads rs=r5 -> ex_a=0x11. With exmem_rd=0 instead -> ex_a=0x22.
- Load-use: `lw r3` in EX, ID reads r3 -> load_use_stall=1 for one cycle, ex_valid=0 on the next edge, then the instruction issues.
- Control priority: stall=1 for 3 cycles -> outputs held. flush=1 with stall=1 -> ex_valid=0, ex_reg_write=0.
- Reset mid-operation: reset high with valid traffic -> all registered outputs 0 on the next edge.
- ALU_FWD_EN undefined: memwb writes r7, ID reads r7 -> load_use_stall=1 and ex_a ignores memwb_result.
